cnn_layer_sequencer: RTL and testbench
======================================

// Module: cnn_layer_sequencer
// PURPOSE
//  Top-level scheduler for the CONV datapath. Runs the layer order:
//  L0 conv (kernel 0, then 1) -> L1 max-pool (k0, k1) -> L2 flatten.
//  Owns the single shared layer-memory port: maps engine requests to csel/cwr/crd.
//  Generates the host ready/busy handshake.
// PARAMETERS
//  ADDR_W   12  layer-memory address width
//  DATA_W   20  layer-memory data width
//  TIMEOUT  0   per-stage watchdog limit in cycles; 0 disables the watchdog
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  ready        in   1       host: input image valid, request start
//  busy         out  1       high from accepted start until sequence end
//  err          out  1       stage watchdog expired during last run
//  stage        out  3       current state encoding (debug)
//  conv_start   out  1       one-cycle start pulse to conv engine
//  pool_start   out  1       one-cycle start pulse to max-pool engine
//  flat_start   out  1       one-cycle start pulse to flatten engine
//  ksel         out  1       kernel index for current L0/L1 stage (0 in L2)
//  conv_done    in   1       conv engine finished current kernel (pulse)
//  pool_done    in   1       pool engine finished current kernel (pulse)
//  flat_done    in   1       flatten engine finished (pulse)
//  eng_cwr      in   1       active engine write request
//  eng_crd      in   1       active engine read request
//  eng_rsel     in   1       L2 only: read source, 0=L1 k0, 1=L1 k1
//  eng_caddr_wr in   ADDR_W  engine write address
//  eng_caddr_rd in   ADDR_W  engine read address
//  eng_cdata_wr in   DATA_W  engine write data
//  rd_stall     out  1       read request dropped this cycle (collision)
//  cwr          out  1       layer-memory write strobe
//  crd          out  1       layer-memory read strobe
//  csel         out  3       layer-memory bank select
//  caddr_wr     out  ADDR_W  pass-through of eng_caddr_wr
//  caddr_rd     out  ADDR_W  pass-through of eng_caddr_rd
//  cdata_wr     out  DATA_W  pass-through of eng_cdata_wr
// BEHAVIOUR
//  Reset (reset=0, async):
//  - State=IDLE. busy, err, all *_start, ksel, cwr, crd, csel and rd_stall are 0.
//  - Reset wins at any point, including mid-stage; no partial-state retention.
//  States and transitions:
//  - IDLE -> L0K0 when ready=1 at a clock edge.
//  - L0K0 -> L0K1 -> L1K0 -> L1K1 -> L2, each stage advancing on its engine's done pulse.
//  - L2 -> DONE on flat_done.
//  - DONE -> IDLE when ready=0. Holding ready=1 in DONE does not restart.
//  busy and start pulses:
//  - busy is registered: 1 in all states except IDLE and DONE. It rises the cycle after ready is sampled.
//  - Each *_start is registered and high exactly during the first cycle of its stage.
//  - ksel = kernel of the current L0/L1 stage.
//  Done handling:
//  - A done pulse is honoured only from the engine owning the current stage, and only after its start cycle.
//  - A done coincident with its start pulse is ignored, as is any done from another engine or in IDLE/DONE.
//  Watchdog (TIMEOUT>0):
//  - Counter clears on each stage entry and increments every cycle in the stage.
//  - When it reaches TIMEOUT: go to DONE, err=1, busy=0.
//  - err clears when the next run starts (IDLE->L0K0).
//  Memory mapping (combinational; all zero in IDLE/DONE):
//  - Write csel: L0Kk = 1+k; L1Kk = 3+k; L2 = 5.
//  - Read csel: L0Kk = 1+k; L1Kk = 1+k; L2 = 3+eng_rsel.
//  - csel = write csel if eng_cwr, else read csel if eng_crd, else 0.
//  - cwr = eng_cwr. crd = eng_crd & ~eng_cwr.
//  - Collision rule: eng_cwr & eng_crd means the write wins; rd_stall=1 that cycle and the engine retries its read.
//  - Address and data pass through unmodified. No added latency; the memory samples them on the next edge.
// TESTING
//  1 Stub engines return done 5 cycles after start; ready=1.
//    -> busy=1 next cycle; starts in order conv(k0), conv(k1), pool(k0), pool(k1), flat.
//    -> busy=0 one cycle after flat_done; err=0.
//  2 csel mapping:
//    L1K1 with eng_cwr=1 -> csel=4, cwr=1. L1K1 with eng_crd=1 -> csel=2, crd=1.
//    L2 with eng_rsel=1 read -> csel=4. L2 write -> csel=5.
//  3 L1K0 with eng_cwr=eng_crd=1 -> cwr=1, crd=0, csel=3, rd_stall=1.
//  4 TIMEOUT=16, conv_done withheld -> 16 cycles into L0K0: err=1, busy=0, stage=DONE.
//    Next ready rise -> err=0 and the run restarts.
//  5 Rejected events: pool_done in L0K0 -> no advance. flat_done in IDLE -> no effect.
//    ready held 1 through DONE -> no restart until ready goes 0 then 1.
//  6 reset=0 asserted mid-L1K0 -> busy, starts, cwr, crd, csel, err all 0 before the next edge.
//    After release, state=IDLE.

Source files
------------

// File: rtl/cnn_layer_sequencer.sv
// Layer scheduler for the CONV datapath: walks L0 conv (k0,k1) -> L1 pool (k0,k1)
// -> L2 flatten, drives the engine start pulses and host busy/err, and maps the
// active engine's memory requests onto the single shared layer-memory port.
module cnn_layer_sequencer #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 20,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic              err,
  output logic [2:0]        stage,
  output logic              conv_start,
  output logic              pool_start,
  output logic              flat_start,
  output logic              ksel,
  input  logic              conv_done,
  input  logic              pool_done,
  input  logic              flat_done,
  input  logic              eng_cwr,
  input  logic              eng_crd,
  input  logic              eng_rsel,
  input  logic [ADDR_W-1:0] eng_caddr_wr,
  input  logic [ADDR_W-1:0] eng_caddr_rd,
  input  logic [DATA_W-1:0] eng_cdata_wr,
  output logic              rd_stall,
  output logic              cwr,
  output logic              crd,
  output logic [2:0]        csel,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic [DATA_W-1:0] cdata_wr
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L0K0 = 3'd1,
    S_L0K1 = 3'd2,
    S_L1K0 = 3'd3,
    S_L1K1 = 3'd4,
    S_L2   = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        conv_start_q, conv_start_d;
  logic        pool_start_q, pool_start_d;
  logic        flat_start_q, flat_start_d;
  logic [31:0] cnt_q, cnt_d;

  logic        in_stage;
  logic        first_cycle;
  logic        done_ok;
  logic        enter;
  logic [2:0]  wr_sel;
  logic [2:0]  rd_sel;

  // State, handshake flags and watchdog counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      conv_start_q <= 1'b0;
      pool_start_q <= 1'b0;
      flat_start_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      conv_start_q <= conv_start_d;
      pool_start_q <= pool_start_d;
      flat_start_q <= flat_start_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next state: advance on the owning engine's done, never in the start cycle
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    in_stage = (state_q != S_IDLE) && (state_q != S_DONE);
    // a start pulse is high exactly in a stage's first cycle
    first_cycle = conv_start_q | pool_start_q | flat_start_q;
    done_ok  = 1'b0;
    case (state_q)
      S_L0K0, S_L0K1: done_ok = conv_done & ~first_cycle;
      S_L1K0, S_L1K1: done_ok = pool_done & ~first_cycle;
      S_L2:           done_ok = flat_done & ~first_cycle;
      default:        done_ok = 1'b0;
    endcase

    case (state_q)
      S_IDLE: if (ready) begin
        state_d = S_L0K0;
        err_d   = 1'b0;
      end
      S_L0K0: if (done_ok) state_d = S_L0K1;
      S_L0K1: if (done_ok) state_d = S_L1K0;
      S_L1K0: if (done_ok) state_d = S_L1K1;
      S_L1K1: if (done_ok) state_d = S_L2;
      S_L2:   if (done_ok) state_d = S_DONE;
      S_DONE: if (!ready)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // watchdog: the stage gets TIMEOUT cycles; a real done in the last one still wins
    if ((TIMEOUT > 0) && in_stage && !done_ok && (cnt_q == 32'(TIMEOUT - 1))) begin
      state_d = S_DONE;
      err_d   = 1'b1;
    end
  end

  // Registered outputs derived from the upcoming state
  always_comb begin
    enter        = (state_d != state_q);
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    conv_start_d = enter && ((state_d == S_L0K0) || (state_d == S_L0K1));
    pool_start_d = enter && ((state_d == S_L1K0) || (state_d == S_L1K1));
    flat_start_d = enter && (state_d == S_L2);
    cnt_d        = cnt_q;
    if (enter)
      cnt_d = '0;
    else if ((TIMEOUT > 0) && in_stage)
      cnt_d = cnt_q + 32'd1;
  end

  // Layer-memory bank mapping; the port is idle outside the working stages
  always_comb begin
    wr_sel = 3'd0;
    rd_sel = 3'd0;
    case (state_q)
      S_L0K0: begin wr_sel = 3'd1; rd_sel = 3'd1; end
      S_L0K1: begin wr_sel = 3'd2; rd_sel = 3'd2; end
      S_L1K0: begin wr_sel = 3'd3; rd_sel = 3'd1; end
      S_L1K1: begin wr_sel = 3'd4; rd_sel = 3'd2; end
      S_L2:   begin wr_sel = 3'd5; rd_sel = 3'd3 + {2'b00, eng_rsel}; end
      default: begin wr_sel = 3'd0; rd_sel = 3'd0; end
    endcase
    // write wins a collision; the engine re-issues the read
    cwr      = in_stage & eng_cwr;
    crd      = in_stage & eng_crd & ~eng_cwr;
    rd_stall = in_stage & eng_cwr & eng_crd;
    csel     = cwr ? wr_sel : (crd ? rd_sel : 3'd0);
  end

  assign busy       = busy_q;
  assign err        = err_q;
  assign stage      = state_q;
  assign conv_start = conv_start_q;
  assign pool_start = pool_start_q;
  assign flat_start = flat_start_q;
  assign ksel       = (state_q == S_L0K1) || (state_q == S_L1K1);
  assign caddr_wr   = eng_caddr_wr;
  assign caddr_rd   = eng_caddr_rd;
  assign cdata_wr   = eng_cdata_wr;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: stub-engine run, memory-map vector
// table, watchdog expiry/restart, rejected events and mid-run reset.
module tb_cnn_layer_sequencer;
  localparam int AW = 12;
  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ready = 1'b0;
  logic          busy, err, conv_start, pool_start, flat_start, ksel;
  logic [2:0]    stage, csel;
  logic          conv_done = 1'b0, pool_done = 1'b0, flat_done = 1'b0;
  logic          eng_cwr = 1'b0, eng_crd = 1'b0, eng_rsel = 1'b0;
  logic [AW-1:0] eng_caddr_wr = '0, eng_caddr_rd = '0;
  logic [DW-1:0] eng_cdata_wr = '0;
  logic          rd_stall, cwr, crd;
  logic [AW-1:0] caddr_wr, caddr_rd;
  logic [DW-1:0] cdata_wr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cnn_layer_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy), .err(err), .stage(stage),
    .conv_start(conv_start), .pool_start(pool_start), .flat_start(flat_start), .ksel(ksel),
    .conv_done(conv_done), .pool_done(pool_done), .flat_done(flat_done),
    .eng_cwr(eng_cwr), .eng_crd(eng_crd), .eng_rsel(eng_rsel),
    .eng_caddr_wr(eng_caddr_wr), .eng_caddr_rd(eng_caddr_rd), .eng_cdata_wr(eng_cdata_wr),
    .rd_stall(rd_stall), .cwr(cwr), .crd(crd), .csel(csel),
    .caddr_wr(caddr_wr), .caddr_rd(caddr_rd), .cdata_wr(cdata_wr)
  );

  typedef struct {
    int       stg;
    logic     wr, rd, rsel;
    logic [2:0] e_csel;
    logic     e_cwr, e_crd, e_stall;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic set_done(input int stg, input logic v);
    conv_done = v && (stg == 1 || stg == 2);
    pool_done = v && (stg == 3 || stg == 4);
    flat_done = v && (stg == 5);
  endtask

  // Move from stage 'from' to the next one using the owning engine's done
  task automatic advance(input int from);
    if (from == 0) begin
      ready = 1'b1;
      tick();
      ready = 1'b0;
    end else begin
      tick();
      set_done(from, 1'b1);
      tick();
      set_done(from, 1'b0);
    end
    chk("advance_stage", 32'(stage), 32'(from + 1));
  endtask

  vec_t vt[$];
  int   seq[$];
  int   exp_seq[5] = '{0, 1, 2, 3, 4};

  initial begin
    int cur;
    int cnt;
    int kind;
    bit fin;
    bit flat_fired;

    vt.push_back('{0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0});
    vt.push_back('{1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0});
    vt.push_back('{2, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0});
    vt.push_back('{2, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0});
    vt.push_back('{3, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0});
    vt.push_back('{3, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0});
    vt.push_back('{3, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1});
    vt.push_back('{4, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0});
    vt.push_back('{4, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0});
    vt.push_back('{5, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0});
    vt.push_back('{5, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0});
    vt.push_back('{5, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0});
    vt.push_back('{6, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});

    // ---- reset state
    do_reset();
    chk("rst_stage", 32'(stage), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_starts", {29'd0, conv_start, pool_start, flat_start}, 32'd0);
    chk("rst_ksel", 32'(ksel), 32'd0);

    // ---- full run with 5-cycle stub engines
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("run_busy_rise", 32'(busy), 32'd1);
    cnt = -1; kind = 0; fin = 0; flat_fired = 0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      set_done(0, 1'b0);
      if (flat_fired) begin
        chk("run_busy_end", 32'(busy), 32'd0);
        chk("run_err_end", 32'(err), 32'd0);
        chk("run_stage_end", 32'(stage), 32'd6);
        fin = 1;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            conv_done = (kind == 0);
            pool_done = (kind == 1);
            flat_done = (kind == 2);
            if (kind == 2) flat_fired = 1;
          end
        end
        if (conv_start) begin seq.push_back(0 + int'(ksel)); kind = 0; cnt = 5; end
        if (pool_start) begin seq.push_back(2 + int'(ksel)); kind = 1; cnt = 5; end
        if (flat_start) begin seq.push_back(4 + int'(ksel)); kind = 2; cnt = 5; end
        tick();
      end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL run_timeout: sequence did not complete within 300 cycles");
    end
    chk("run_start_count", 32'(seq.size()), 32'd5);
    for (int i = 0; i < 5 && i < seq.size(); i++)
      chk("run_start_order", 32'(seq[i]), 32'(exp_seq[i]));

    // ---- memory mapping vector table
    tick();
    chk("back_to_idle", 32'(stage), 32'd0);
    cur = 0;
    foreach (vt[i]) begin
      while (cur < vt[i].stg) begin
        eng_cwr = 1'b0; eng_crd = 1'b0; eng_rsel = 1'b0;
        advance(cur);
        cur++;
      end
      eng_cwr = vt[i].wr; eng_crd = vt[i].rd; eng_rsel = vt[i].rsel;
      eng_caddr_wr = AW'(12'h100 + i); eng_caddr_rd = AW'(12'h200 + i);
      eng_cdata_wr = DW'(20'hABC00 + i);
      #1;
      chk("map_csel", 32'(csel), 32'(vt[i].e_csel));
      chk("map_cwr", 32'(cwr), 32'(vt[i].e_cwr));
      chk("map_crd", 32'(crd), 32'(vt[i].e_crd));
      chk("map_stall", 32'(rd_stall), 32'(vt[i].e_stall));
      chk("map_addr_wr", 32'(caddr_wr), 32'(12'h100 + i));
      chk("map_addr_rd", 32'(caddr_rd), 32'(12'h200 + i));
      chk("map_data_wr", 32'(cdata_wr), 32'(20'hABC00 + i));
    end
    eng_cwr = 1'b0; eng_crd = 1'b0; eng_rsel = 1'b0;

    // ---- watchdog: conv_done withheld
    do_reset();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("wd_enter", 32'(stage), 32'd1);
    for (int k = 0; k < 15; k++) tick();
    chk("wd_before_stage", 32'(stage), 32'd1);
    chk("wd_before_busy", 32'(busy), 32'd1);
    tick();
    chk("wd_stage", 32'(stage), 32'd6);
    chk("wd_err", 32'(err), 32'd1);
    chk("wd_busy", 32'(busy), 32'd0);
    tick();
    chk("wd_idle", 32'(stage), 32'd0);
    chk("wd_err_held", 32'(err), 32'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("wd_restart_stage", 32'(stage), 32'd1);
    chk("wd_restart_err", 32'(err), 32'd0);
    chk("wd_restart_start", 32'(conv_start), 32'd1);

    // ---- rejected events
    do_reset();
    flat_done = 1'b1;
    tick();
    flat_done = 1'b0;
    chk("rej_flat_idle", 32'(stage), 32'd0);
    ready = 1'b1;
    tick();
    conv_done = 1'b1;          // coincident with conv_start
    tick();
    conv_done = 1'b0;
    chk("rej_done_at_start", 32'(stage), 32'd1);
    pool_done = 1'b1;          // wrong engine
    tick();
    pool_done = 1'b0;
    chk("rej_pool_in_l0", 32'(stage), 32'd1);
    cur = 1;
    while (cur < 6) begin
      advance(cur);
      cur++;
    end
    for (int k = 0; k < 3; k++) tick();
    chk("rej_done_hold_stage", 32'(stage), 32'd6);
    chk("rej_done_hold_busy", 32'(busy), 32'd0);
    ready = 1'b0;
    tick();
    chk("rej_idle", 32'(stage), 32'd0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("rej_restart", 32'(stage), 32'd1);

    // ---- asynchronous reset mid-L1K0
    do_reset();
    cur = 0;
    while (cur < 3) begin
      advance(cur);
      cur++;
    end
    eng_cwr = 1'b1; eng_crd = 1'b1;
    #1;
    chk("ar_pre_csel", 32'(csel), 32'd3);
    reset = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_err", 32'(err), 32'd0);
    chk("ar_starts", {29'd0, conv_start, pool_start, flat_start}, 32'd0);
    chk("ar_mem", {28'd0, cwr, crd, csel}, 32'd0);
    chk("ar_stall", 32'(rd_stall), 32'd0);
    tick();
    reset = 1'b1;
    eng_cwr = 1'b0; eng_crd = 1'b0;
    tick();
    chk("ar_idle", 32'(stage), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
